// File: rtl/spi_frame_receiver.sv
// SPI target receiver for 40-bit configuration frames (header/addr/cmd/data, MSB first).
// Pins are synchronised into clk, deserialised, validated and reported with one-cycle strobes.
module spi_frame_receiver #(
    parameter logic [7:0]  HEADER_BYTE = 8'hFF,
    parameter logic [7:0]  CMD_BYTE    = 8'h01,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs_l,
    input  logic        spi_sclk,
    input  logic        spi_data,
    output logic [15:0] rx_addr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_err,
    output logic [1:0]  err_code,
    output logic [5:0]  bit_count,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_CS
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_cs_d;
    logic                   r_sclk_d;
    logic                   r_overrun;
    logic [38:0]            r_shift;

    logic                   w_cs_s;
    logic                   w_sclk_s;
    logic                   w_data_s;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_sclk_rise;
    logic [39:0]            w_word;
    logic                   w_last_bit;

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    // r_shift holds the first 39 bits; the 40th is taken straight from the synchroniser
    // so the frame can be judged on the same edge that delivers it.
    assign w_word      = {r_shift, w_data_s};
    assign w_last_bit  = w_sclk_rise && (bit_count == 6'd39);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_data_sync <= '0;
            r_cs_d      <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_l};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_data};
            r_cs_d      <= w_cs_s;
            r_sclk_d    <= w_sclk_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
            rx_addr     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            err_code    <= '0;
            bit_count   <= '0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    bit_count <= '0;
                    busy      <= 1'b0;
                    if (w_cs_fall) begin
                        r_state   <= ST_SHIFT;
                        busy      <= 1'b1;
                        r_shift   <= '0;
                        r_overrun <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_shift   <= w_word[38:0];
                        bit_count <= bit_count + 6'd1;
                    end
                    if (w_last_bit) begin
                        if (w_word[39:32] != HEADER_BYTE) begin
                            rx_err   <= 1'b1;
                            err_code <= 2'd1;
                        end else if (w_word[15:8] != CMD_BYTE) begin
                            rx_err   <= 1'b1;
                            err_code <= 2'd2;
                        end else begin
                            rx_valid    <= 1'b1;
                            rx_addr     <= w_word[31:16];
                            rx_data     <= w_word[7:0];
                            frame_count <= frame_count + 16'd1;
                        end
                        // A cs rise in the same cycle completes the frame and closes it.
                        if (w_cs_rise) begin
                            r_state   <= ST_IDLE;
                            busy      <= 1'b0;
                            bit_count <= '0;
                        end else begin
                            r_state <= ST_WAIT_CS;
                        end
                    end else if (w_cs_rise) begin
                        rx_err    <= 1'b1;
                        err_code  <= 2'd3;
                        bit_count <= '0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WAIT_CS: begin
                    if (w_sclk_rise && !r_overrun) begin
                        rx_err    <= 1'b1;
                        err_code  <= 2'd3;
                        r_overrun <= 1'b1;
                    end
                    if (w_cs_rise) begin
                        r_state   <= ST_IDLE;
                        busy      <= 1'b0;
                        bit_count <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed and random frames against a
// frame-level reference model of header/command/length rules.
module tb_spi_frame_receiver;

    localparam int unsigned SYNC   = 2;
    localparam int          PERIOD = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs_l;
    logic        spi_sclk;
    logic        spi_data;
    logic [15:0] rx_addr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [1:0]  err_code;
    logic [5:0]  bit_count;
    logic        busy;
    logic [15:0] frame_count;

    always #(PERIOD/2) clk = ~clk;

    spi_frame_receiver #(
        .HEADER_BYTE (8'hFF),
        .CMD_BYTE    (8'h01),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs_l    (spi_cs_l),
        .spi_sclk    (spi_sclk),
        .spi_data    (spi_data),
        .rx_addr     (rx_addr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .err_code    (err_code),
        .bit_count   (bit_count),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] got_valid[$];
    logic [1:0]  got_err[$];
    logic [23:0] exp_valid[$];
    logic [1:0]  exp_err[$];
    int          both_high = 0;
    time         t_strobe = 0;
    time         t_bit40 = 0;
    time         t_csrise = 0;

    logic [15:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic [15:0] m_count = '0;
    logic [1:0]  m_code = '0;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_valid.push_back({rx_addr, rx_data});
            t_strobe = $time;
        end
        if (rx_err) begin
            got_err.push_back(err_code);
            t_strobe = $time;
        end
        if (rx_valid && rx_err) both_high++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level rules: short -> length error; 40 bits judged on header then command;
    // any bit beyond 40 adds one length error.
    function automatic void model(input logic [63:0] word, input int nbits);
        logic [39:0] f;
        if (nbits < 40) begin
            exp_err.push_back(2'd3);
            m_code = 2'd3;
            return;
        end
        f = word[nbits-1 -: 40];
        if (f[39:32] != 8'hFF) begin
            exp_err.push_back(2'd1);
            m_code = 2'd1;
        end else if (f[15:8] != 8'h01) begin
            exp_err.push_back(2'd2);
            m_code = 2'd2;
        end else begin
            m_addr  = f[31:16];
            m_data  = f[7:0];
            m_count = m_count + 16'd1;
            exp_valid.push_back({m_addr, m_data});
        end
        if (nbits > 40) begin
            exp_err.push_back(2'd3);
            m_code = 2'd3;
        end
    endfunction

    task automatic send(input logic [63:0] word, input int nbits, input int half,
                        input bit raise_cs, input bit cs_with_last, input int gap);
        spi_cs_l = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_data = word[i];
            repeat (half) @(negedge clk);
            spi_sclk = 1'b1;
            if (nbits - 1 - i == 39) t_bit40 = $time;
            if (i == 0 && cs_with_last) spi_cs_l = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
        end
        if (raise_cs && !cs_with_last) begin
            spi_cs_l = 1'b1;
            t_csrise = $time;
        end
        if (raise_cs) repeat (gap) @(negedge clk);
    endtask

    task automatic settle();
        repeat (SYNC + 6) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        chk({tag, " n_valid"}, got_valid.size(), exp_valid.size());
        chk({tag, " n_err"}, got_err.size(), exp_err.size());
        while (got_valid.size() > 0 && exp_valid.size() > 0)
            chk({tag, " addr_data"}, got_valid.pop_front(), exp_valid.pop_front());
        while (got_err.size() > 0 && exp_err.size() > 0)
            chk({tag, " err_code_pulse"}, got_err.pop_front(), exp_err.pop_front());
        got_valid.delete();
        got_err.delete();
        exp_valid.delete();
        exp_err.delete();
        chk({tag, " rx_addr"}, rx_addr, m_addr);
        chk({tag, " rx_data"}, rx_data, m_data);
        chk({tag, " frame_count"}, frame_count, m_count);
        chk({tag, " err_code"}, err_code, m_code);
        chk({tag, " bit_count"}, bit_count, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        logic [63:0] w;
        logic [7:0]  hdr;
        logic [7:0]  cmd;
        reset    = 1'b1;
        spi_cs_l = 1'b1;
        spi_sclk = 1'b0;
        spi_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {rx_addr, rx_data, rx_valid, rx_err, err_code},  '0);
        chk("reset counters", {bit_count, busy, frame_count}, '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        w = 64'hFF_1234_01_AB;
        send(w, 40, 1, 1'b1, 1'b0, 2);
        settle();
        model(w, 40);
        chk("good latency", int'(t_strobe - t_bit40), (SYNC + 1) * PERIOD);
        compare("good");

        w = 64'hFE_1234_01_AB;
        send(w, 40, 1, 1'b1, 1'b0, 2);
        settle();
        model(w, 40);
        compare("bad header");

        w = 64'hFF_1234_02_AB;
        send(w, 40, 2, 1'b1, 1'b0, 2);
        settle();
        model(w, 40);
        compare("bad cmd");

        w = 64'hFF_00C0_01_5A >> 20;
        send(w, 20, 1, 1'b1, 1'b0, 2);
        settle();
        model(w, 20);
        chk("short latency", int'(t_strobe - t_csrise), (SYNC + 1) * PERIOD);
        compare("short");
        w = 64'hFF_00C0_01_5A;
        send(w, 40, 1, 1'b1, 1'b0, 2);
        settle();
        model(w, 40);
        compare("after short");

        for (int k = 1; k <= 3; k++) begin
            w = {24'd0, 8'hFF, 16'($urandom), 8'h01, 8'(k * 8'h11)};
            model(w, 40);
            send(w, 40, 1, 1'b1, 1'b0, 1);
        end
        settle();
        compare("back-to-back");

        w = {23'd0, 40'hFF_0001_01_01, 1'b1};
        send(w, 41, 1, 1'b1, 1'b0, 2);
        settle();
        model(w, 41);
        compare("overrun");

        w = {24'd0, 8'hFF, 16'($urandom), 8'h01, 8'($urandom)};
        send(w, 40, 2, 1'b1, 1'b1, 0);
        repeat (2) @(negedge clk);
        spi_sclk = 1'b0;
        settle();
        model(w, 40);
        compare("cs with last bit");

        w = 64'hFF_BEEF_01_77 >> 15;
        send(w, 25, 1, 1'b0, 1'b0, 0);
        settle();
        chk("mid bit_count", bit_count, 25);
        chk("mid busy", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset outputs", {rx_addr, rx_data, err_code, bit_count, busy, frame_count}, '0);
        reset   = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_count = '0;
        m_code  = '0;
        repeat (2) @(negedge clk);
        spi_cs_l = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort no strobe", got_valid.size() + got_err.size(), 0);
        w = 64'hFF_BEEF_01_77;
        send(w, 40, 1, 1'b1, 1'b0, 2);
        settle();
        model(w, 40);
        compare("after reset");

        for (int k = 0; k < 10; k++) begin
            hdr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            cmd = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h01;
            w   = {24'd0, hdr, 16'($urandom), cmd, 8'($urandom)};
            send(w, 40, $urandom_range(1, 3), 1'b1, 1'b0, $urandom_range(1, 3));
            settle();
            model(w, 40);
            compare("random");
        end

        chk("valid and err together", both_high, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
